array_mult_ctrl: RTL and testbench
==================================

Name: array_mult_ctrl

Overview:
- Initiator side of the `ifc_array_mult` protocol.
- Host-facing controller that loads N pairs of 27-bit Q18.8 operands into local registers.
- Drives the array multiplier's operand buses and clock-enable for the exact pipeline depth, then captures the N rounded 27-bit products into a readback buffer.
- Sits between the bus slave (register decode) and the array multiplier instance.

Parameters:
- N, 15, number of multiplier lanes (matches array multiplier lane count)
- MULT_LAT, 4, clock-enabled pipeline depth of each 27x27 multiplier core; total array latency = MULT_LAT+1 (rounding stage)
- IDX_W, 4, lane index width, ceil(log2(N))

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- wr_en  in  1  host operand write strobe
- wr_sel  in  1  0 = operand A bank, 1 = operand B bank
- wr_idx  in  IDX_W  lane index for write
- wr_data  in  27  operand value
- start  in  1  single-cycle launch pulse
- rd_idx  in  IDX_W  lane index for result readback
- rd_data  out  27  registered result of lane rd_idx
- busy  out  1  high from accepted start until done
- done  out  1  sticky completion flag
- mult_en  out  1  clock-enable to array multiplier
- mult_dataa  out  N*27  packed operand A, lane k at [27k+26:27k]
- mult_datab  out  N*27  packed operand B, same packing
- mult_result  in  N*27  packed rounded products from array multiplier

Behaviour:
- Clock/reset: one clock `clk`. Reset is synchronous, active-low (`reset_n` sampled on rising edge).
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, mult_en = 0, rd_data = 0
  - operand banks and result buffer cleared to 0
  - latency counter = 0
- Operand writes:
  - Accepted only when busy = 0: bank[wr_sel][wr_idx] <= wr_data.
  - Ignored while busy, or when wr_idx >= N.
  - mult_dataa/mult_datab are driven continuously from the banks.
- FSM states: IDLE, RUN, CAPTURE.
- IDLE:
  - start = 1: clear done, set busy, load counter with MULT_LAT+1, go to RUN.
  - If start and wr_en arrive in the same cycle, the write lands first; the new value is used.
- RUN:
  - mult_en = 1 every cycle; counter decrements each cycle.
  - When counter reaches 1 (the last enabled cycle), go to CAPTURE.
  - mult_en is high for exactly MULT_LAT+1 consecutive cycles.
  - start is ignored in RUN.
- CAPTURE:
  - mult_en = 0; latch all N lanes of mult_result into the result buffer.
  - Set done = 1, clear busy, return to IDLE.
  - Start-to-done latency = MULT_LAT+3 cycles: start sampled edge, MULT_LAT+1 RUN cycles, CAPTURE.
- done stays high until the next accepted start or reset.
- rd_data <= result_buf[rd_idx] each cycle (1-cycle read latency); rd_idx >= N returns 0.
- Result buffer holds the previous run's values until the next CAPTURE. Reading during RUN returns stale, not partial, data.
- No arithmetic in this block; widths pass through unchanged (27 in, 27 out).
- Reset mid-RUN: return to IDLE next edge, mult_en = 0 immediately, buffers cleared. The multiplier pipeline is left stale; the next run flushes it by re-enabling for the full depth.
- Back-to-back: start in the cycle after done rises is accepted normally.

Optional Feature:
- Macro: ARRAY_MULT_CTRL_CYCCNT_EN.
- Defined:
  - Adds output `cyc_cnt` (32 bits) counting clk cycles while busy = 1.
  - Cleared on accepted start, frozen at CAPTURE, reset to 0.
  - Expected value after a run = MULT_LAT+2.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then idle: reset_n = 0 for 2 cycles -> busy = 0, done = 0, mult_en = 0, rd_data = 0 for all rd_idx 0..14.
- Basic multiply, lane 3:
  - Stimulus: A = 256 (1.0), B = 512 (2.0), start.
  - Expected: mult_en high exactly 5 cycles; done rises 7 cycles after start; rd_idx = 3 -> rd_data = 512; other lanes = 0.
- Rounding through multiplier, lane 0:
  - A = 1, B = 128 -> rd_data = 1.
  - A = 1, B = 127 -> rd_data = 0.
  - Checks that capture aligns with the rounding stage.
- Busy protection:
  - During RUN, write A[3] = 999 and pulse start again.
  - Expected: write dropped, second start ignored, single done; A[3] still 256 on the next run.
- Mid-run reset:
  - Assert reset_n = 0 on the 2nd RUN cycle -> next cycle state IDLE, mult_en = 0, done = 0, buffer = 0.
  - Fresh run then yields correct products.
- Back-to-back runs:
  - Run 1: all lanes A = B = 256 -> results 256.
  - Change B[14] = 768 and start one cycle after done -> lane 14 = 768, others 256; done re-pulses after 7 cycles.
  - With ARRAY_MULT_CTRL_CYCCNT_EN defined: cyc_cnt = 6.

Source files
------------

// File: rtl/array_mult_ctrl.sv
// ============================================================================
// Module      : array_mult_ctrl
// Description : Initiator for the ifc_array_mult protocol. Holds N operand
//               pairs, enables the multiplier array for its full pipeline
//               depth, then captures the rounded products for readback.
//               Optional cycle counter: define ARRAY_MULT_CTRL_CYCCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_mult_ctrl #(
  parameter int N        = 15,
  parameter int MULT_LAT = 4,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [26:0]         wr_data,
  input  logic                start,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [26:0]         rd_data,
  output logic                busy,
  output logic                done,
  output logic                mult_en,
  output logic [N*27-1:0]     mult_dataa,
  output logic [N*27-1:0]     mult_datab,
  input  logic [N*27-1:0]     mult_result
`ifdef ARRAY_MULT_CTRL_CYCCNT_EN
  ,
  output logic [31:0]         cyc_cnt
`endif
);

  localparam int               c_DW       = 27;
  localparam int               c_CNT_W    = $clog2(MULT_LAT + 2);
  localparam logic [c_CNT_W-1:0] c_RUN_LOAD = c_CNT_W'(MULT_LAT + 1);
  localparam logic [IDX_W:0]   c_N        = (IDX_W + 1)'(N);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [c_DW-1:0]      r_rd_data;
  logic                 w_start_ok;
  logic                 w_run;
  logic                 w_capture;
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic [c_DW-1:0]      w_result [N];

  assign w_wr_ok = wr_en && !r_busy && ({1'b0, wr_idx} < c_N);
  assign w_rd_ok = ({1'b0, rd_idx} < c_N);

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_run       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_run = 1'b1;
        // Count value 1 marks the last enabled cycle of the pipeline flush
        if (r_cnt == c_CNT_W'(1)) begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_cnt  <= c_RUN_LOAD;
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end else if (w_run) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end
      if (w_capture) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  // Gating with reset_n drops the enable in the same cycle reset is asserted
  assign mult_en = w_run & reset_n;
  assign busy    = r_busy;
  assign done    = r_done;

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_lane
      logic [c_DW-1:0] r_a;
      logic [c_DW-1:0] r_b;
      logic [c_DW-1:0] r_res;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_a   <= '0;
          r_b   <= '0;
          r_res <= '0;
        end else begin
          if (w_wr_ok && (wr_idx == IDX_W'(k))) begin
            if (wr_sel) begin
              r_b <= wr_data;
            end else begin
              r_a <= wr_data;
            end
          end
          if (w_capture) begin
            r_res <= mult_result[k*c_DW +: c_DW];
          end
        end
      end

      assign mult_dataa[k*c_DW +: c_DW] = r_a;
      assign mult_datab[k*c_DW +: c_DW] = r_b;
      assign w_result[k]                = r_res;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else if (w_rd_ok) begin
      r_rd_data <= w_result[rd_idx];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign rd_data = r_rd_data;

`ifdef ARRAY_MULT_CTRL_CYCCNT_EN
  logic [31:0] r_cyc_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cyc_cnt <= '0;
    end else if (w_start_ok) begin
      r_cyc_cnt <= '0;
    end else if (r_busy) begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_array_mult_ctrl.sv
// ============================================================================
// Module      : tb_array_mult_ctrl
// Description : Directed self-checking bench for array_mult_ctrl with a
//               clock-enabled behavioural model of the multiplier array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_array_mult_ctrl;

  localparam int N        = 15;
  localparam int MULT_LAT = 4;
  localparam int IDX_W    = 4;
  localparam int DW       = 27;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               wr_en;
  logic               wr_sel;
  logic [IDX_W-1:0]   wr_idx;
  logic [DW-1:0]      wr_data;
  logic               start;
  logic [IDX_W-1:0]   rd_idx;
  logic [DW-1:0]      rd_data;
  logic               busy;
  logic               done;
  logic               mult_en;
  logic [N*DW-1:0]    mult_dataa;
  logic [N*DW-1:0]    mult_datab;
  logic [N*DW-1:0]    mult_result;
`ifdef ARRAY_MULT_CTRL_CYCCNT_EN
  logic [31:0]        cyc_cnt;
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  array_mult_ctrl #(.N(N), .MULT_LAT(MULT_LAT), .IDX_W(IDX_W)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .start       (start),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .mult_en     (mult_en),
    .mult_dataa  (mult_dataa),
    .mult_datab  (mult_datab),
    .mult_result (mult_result)
`ifdef ARRAY_MULT_CTRL_CYCCNT_EN
    ,
    .cyc_cnt     (cyc_cnt)
`endif
  );

  // Multiplier array model: Q18.8 product rounded half-up, MULT_LAT+1 enabled stages
  function automatic logic [N*DW-1:0] prod(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
    logic [N*DW-1:0]    r;
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    logic signed [53:0] p;
    r = '0;
    for (int i = 0; i < N; i++) begin
      x = a[i*DW +: DW];
      y = b[i*DW +: DW];
      p = 54'(x) * 54'(y);
      p = p + 54'sd128;
      r[i*DW +: DW] = DW'(p >>> 8);
    end
    return r;
  endfunction

  logic [N*DW-1:0] pipe [0:MULT_LAT];

  always @(posedge clk) begin
    if (mult_en) begin
      pipe[0] <= prod(mult_dataa, mult_datab);
      for (int s = 1; s <= MULT_LAT; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign mult_result = pipe[MULT_LAT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_op(input logic sel, input int idx, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_idx  = IDX_W'(idx);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic check_lane(input string tag, input int idx, input logic [DW-1:0] exp);
    rd_idx = IDX_W'(idx);
    tick();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  // Pulses start, then counts enabled cycles and start-to-done latency
  task automatic run(output int en_cnt, output int lat);
    start = 1'b1;
    tick();
    start  = 1'b0;
    wr_en  = 1'b0;
    lat    = 1;
    en_cnt = 0;
    while (!done && lat < 30) begin
      if (mult_en) en_cnt++;
      tick();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int en_cnt;
    int lat;
    int extra;

    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    start   = 1'b0;
    rd_idx  = '0;

    // Reset then idle
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_en", 32'(mult_en), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) check_lane("rst_rd", i, 27'd0);

    // Basic multiply on lane 3: 1.0 * 2.0
    write_op(1'b0, 3, 27'd256);
    write_op(1'b1, 3, 27'd512);
    run(en_cnt, lat);
    check("basic_en_cycles", 32'(en_cnt), 32'd5);
    check("basic_latency", 32'(lat), 32'd7);
    check("basic_busy", 32'(busy), 32'd0);
    check_lane("basic_lane3", 3, 27'd512);
    check_lane("basic_lane2", 2, 27'd0);
    check_lane("basic_lane14", 14, 27'd0);
    check_lane("rd_oob", 15, 27'd0);

    // Rounding on lane 0
    write_op(1'b0, 0, 27'd1);
    write_op(1'b1, 0, 27'd128);
    run(en_cnt, lat);
    check_lane("round_up", 0, 27'd1);
    write_op(1'b1, 0, 27'd127);
    run(en_cnt, lat);
    check_lane("round_down", 0, 27'd0);
    check_lane("round_lane3_kept", 3, 27'd512);

    // Busy protection: write and second start during RUN are dropped
    start = 1'b1;
    tick();
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_idx  = IDX_W'(3);
    wr_data = 27'd999;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    lat   = 2;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    check("busy_latency", 32'(lat), 32'd7);
    extra = 0;
    repeat (8) begin
      if (mult_en) extra++;
      tick();
    end
    check("busy_no_rerun", 32'(extra), 32'd0);
    check("busy_done_held", 32'(done), 32'd1);
    check("busy_opa_kept", 32'(mult_dataa[3*DW +: DW]), 32'd256);
    check_lane("busy_lane3", 3, 27'd512);
    run(en_cnt, lat);
    check_lane("busy_rerun_lane3", 3, 27'd512);

    // Reset on the second RUN cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("midrst_en_gate", 32'(mult_en), 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_en", 32'(mult_en), 32'd0);
    check("midrst_bank", 32'(mult_dataa[3*DW +: DW]), 32'd0);
    check_lane("midrst_buf", 3, 27'd0);
    write_op(1'b0, 5, 27'd768);
    write_op(1'b1, 5, 27'd1280);
    run(en_cnt, lat);
    check("midrst_fresh_lat", 32'(lat), 32'd7);
    check_lane("midrst_fresh_lane5", 5, 27'd3840);

    // Back-to-back runs
    for (int i = 0; i < N; i++) begin
      write_op(1'b0, i, 27'd256);
      write_op(1'b1, i, 27'd256);
    end
    run(en_cnt, lat);
    check("b2b_run1_lat", 32'(lat), 32'd7);
`ifdef ARRAY_MULT_CTRL_CYCCNT_EN
    check("b2b_run1_cyc", cyc_cnt, 32'd6);
`endif
    // Write and start together in the cycle after done rises
    wr_en   = 1'b1;
    wr_sel  = 1'b1;
    wr_idx  = IDX_W'(14);
    wr_data = 27'd768;
    run(en_cnt, lat);
    check("b2b_run2_en", 32'(en_cnt), 32'd5);
    check("b2b_run2_lat", 32'(lat), 32'd7);
    check_lane("b2b_lane0", 0, 27'd256);
    check_lane("b2b_lane13", 13, 27'd256);
    check_lane("b2b_lane14", 14, 27'd768);
`ifdef ARRAY_MULT_CTRL_CYCCNT_EN
    check("b2b_run2_cyc", cyc_cnt, 32'd6);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
